// File: rtl/alu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | alu_pkg : ALUOp, funct and ALU-control encodings for the EX stage     |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
package alu_pkg;

  // ALUOp values produced by the main decoder
  localparam logic [2:0] ALUOP_ADD   = 3'b000;
  localparam logic [2:0] ALUOP_SUB   = 3'b001;
  localparam logic [2:0] ALUOP_RTYPE = 3'b010;
  localparam logic [2:0] ALUOP_SLT   = 3'b011;
  localparam logic [2:0] ALUOP_OR    = 3'b100;
  localparam logic [2:0] ALUOP_AND   = 3'b101;

  // R-type funct field values
  localparam logic [5:0] FUNCT_ADD = 6'b100000;
  localparam logic [5:0] FUNCT_SUB = 6'b100010;
  localparam logic [5:0] FUNCT_AND = 6'b100100;
  localparam logic [5:0] FUNCT_OR  = 6'b100101;
  localparam logic [5:0] FUNCT_NOR = 6'b100111;
  localparam logic [5:0] FUNCT_SLT = 6'b101010;

  // ALU control codes
  localparam logic [3:0] ALUCTRL_AND = 4'b0000;
  localparam logic [3:0] ALUCTRL_OR  = 4'b0001;
  localparam logic [3:0] ALUCTRL_ADD = 4'b0010;
  localparam logic [3:0] ALUCTRL_SUB = 4'b0110;
  localparam logic [3:0] ALUCTRL_SLT = 4'b0111;
  localparam logic [3:0] ALUCTRL_NOR = 4'b1100;

endpackage
`default_nettype wire

// File: rtl/alu_ctrl_dec.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | alu_ctrl_dec : combinational ALUOp/funct to 4-bit ALU control decode  |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module alu_ctrl_dec
  import alu_pkg::*;
(
  input  logic [2:0] i_alu_op,
  input  logic [5:0] i_funct,
  output logic [3:0] o_alu_ctrl
);

  logic [3:0] w_funct_ctrl;

  // Unrecognised funct values fall back to ADD
  always_comb begin
    w_funct_ctrl = ALUCTRL_ADD;
    case (i_funct)
      FUNCT_ADD: w_funct_ctrl = ALUCTRL_ADD;
      FUNCT_SUB: w_funct_ctrl = ALUCTRL_SUB;
      FUNCT_AND: w_funct_ctrl = ALUCTRL_AND;
      FUNCT_OR:  w_funct_ctrl = ALUCTRL_OR;
      FUNCT_NOR: w_funct_ctrl = ALUCTRL_NOR;
      FUNCT_SLT: w_funct_ctrl = ALUCTRL_SLT;
      default:   w_funct_ctrl = ALUCTRL_ADD;
    endcase
  end

  always_comb begin
    o_alu_ctrl = ALUCTRL_ADD;
    case (i_alu_op)
      ALUOP_ADD:   o_alu_ctrl = ALUCTRL_ADD;
      ALUOP_SUB:   o_alu_ctrl = ALUCTRL_SUB;
      ALUOP_RTYPE: o_alu_ctrl = w_funct_ctrl;
      ALUOP_SLT:   o_alu_ctrl = ALUCTRL_SLT;
      ALUOP_OR:    o_alu_ctrl = ALUCTRL_OR;
      ALUOP_AND:   o_alu_ctrl = ALUCTRL_AND;
      default:     o_alu_ctrl = ALUCTRL_ADD;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/alu_exec_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | alu_exec_unit : EX-stage ALU, branch-target adder, registered outputs |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module alu_exec_unit
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic [2:0]       alu_op_i,
  input  logic [5:0]       funct_i,
  input  logic [WIDTH-1:0] src1_i,
  input  logic [WIDTH-1:0] src2_i,
  input  logic [WIDTH-1:0] pc_i,
  input  logic [WIDTH-1:0] imm_i,
  output logic [WIDTH-1:0] result_o,
  output logic [1:0]       zero_o,
  output logic [WIDTH-1:0] branch_addr_o,
  output logic [3:0]       alu_ctrl_o
);

  logic [3:0]       w_alu_ctrl;
  logic [WIDTH-1:0] w_alu_result;
  logic [1:0]       w_flags;
  logic [WIDTH-1:0] w_branch_addr;
  logic             w_slt;

  logic [WIDTH-1:0] r_result;
  logic [1:0]       r_zero;
  logic [WIDTH-1:0] r_branch_addr;
  logic [3:0]       r_alu_ctrl;

  alu_ctrl_dec u_alu_ctrl_dec (
    .i_alu_op   (alu_op_i),
    .i_funct    (funct_i),
    .o_alu_ctrl (w_alu_ctrl)
  );

  assign w_slt = ($signed(src1_i) < $signed(src2_i));

  // Codes outside the supported set produce zero
  always_comb begin
    w_alu_result = '0;
    case (w_alu_ctrl)
      ALUCTRL_AND: w_alu_result = src1_i & src2_i;
      ALUCTRL_OR:  w_alu_result = src1_i | src2_i;
      ALUCTRL_ADD: w_alu_result = src1_i + src2_i;
      ALUCTRL_SUB: w_alu_result = src1_i - src2_i;
      ALUCTRL_SLT: w_alu_result = {{(WIDTH-1){1'b0}}, w_slt};
      ALUCTRL_NOR: w_alu_result = ~(src1_i | src2_i);
      default:     w_alu_result = '0;
    endcase
  end

  assign w_flags       = {w_alu_result[WIDTH-1], (w_alu_result == '0)};
  assign w_branch_addr = pc_i + {imm_i[WIDTH-3:0], 2'b00};

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_result      <= '0;
      r_zero        <= 2'b00;
      r_branch_addr <= '0;
      r_alu_ctrl    <= 4'b0000;
    end else if (en_i) begin
      r_result      <= w_alu_result;
      r_zero        <= w_flags;
      r_branch_addr <= w_branch_addr;
      r_alu_ctrl    <= w_alu_ctrl;
    end
  end

  assign result_o      = r_result;
  assign zero_o        = r_zero;
  assign branch_addr_o = r_branch_addr;
  assign alu_ctrl_o    = r_alu_ctrl;

endmodule
`default_nettype wire

// File: tb/tb_alu_exec_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_alu_exec_unit : randomized + directed self-checking bench          |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module tb_alu_exec_unit;

  localparam int WIDTH = 32;

  logic             clk_i;
  logic             rst_i;
  logic             en_i;
  logic [2:0]       alu_op_i;
  logic [5:0]       funct_i;
  logic [WIDTH-1:0] src1_i, src2_i, pc_i, imm_i;
  logic [WIDTH-1:0] result_o, branch_addr_o;
  logic [1:0]       zero_o;
  logic [3:0]       alu_ctrl_o;

  int errors = 0;
  int checks = 0;

  // Reference state: what the outputs should currently show
  logic [WIDTH-1:0] m_result, m_branch;
  logic [1:0]       m_zero;
  logic [3:0]       m_ctrl;

  alu_exec_unit #(.WIDTH(WIDTH)) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .en_i          (en_i),
    .alu_op_i      (alu_op_i),
    .funct_i       (funct_i),
    .src1_i        (src1_i),
    .src2_i        (src2_i),
    .pc_i          (pc_i),
    .imm_i         (imm_i),
    .result_o      (result_o),
    .zero_o        (zero_o),
    .branch_addr_o (branch_addr_o),
    .alu_ctrl_o    (alu_ctrl_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Operation named by the ISA semantics: 0=add 1=sub 2=and 3=or 4=nor 5=slt
  function automatic int op_of(input logic [2:0] op, input logic [5:0] f);
    if (op == 3'd1) return 1;
    if (op == 3'd3) return 5;
    if (op == 3'd4) return 3;
    if (op == 3'd5) return 2;
    if (op == 3'd2) begin
      if (f == 6'h20) return 0;
      if (f == 6'h22) return 1;
      if (f == 6'h24) return 2;
      if (f == 6'h25) return 3;
      if (f == 6'h27) return 4;
      if (f == 6'h2A) return 5;
    end
    return 0;
  endfunction

  function automatic logic [3:0] code_of(input int k);
    logic [3:0] tbl [6] = '{4'b0010, 4'b0110, 4'b0000, 4'b0001, 4'b1100, 4'b0111};
    return tbl[k];
  endfunction

  function automatic logic [WIDTH-1:0] calc(input int k, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    longint sa, sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (k)
      0: return WIDTH'(sa + sb);
      1: return WIDTH'(sa - sb);
      2: return a & b;
      3: return a | b;
      4: return ~(a | b);
      default: return (sa < sb) ? WIDTH'(1) : WIDTH'(0);
    endcase
  endfunction

  task automatic step(input logic r, input logic e, input logic [2:0] op, input logic [5:0] f,
                      input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                      input logic [WIDTH-1:0] pc, input logic [WIDTH-1:0] imm, input string tag);
    int k;
    rst_i = r; en_i = e; alu_op_i = op; funct_i = f;
    src1_i = a; src2_i = b; pc_i = pc; imm_i = imm;
    @(posedge clk_i);
    if (!r) begin
      m_result = '0; m_zero = 2'b00; m_branch = '0; m_ctrl = 4'b0000;
    end else if (e) begin
      k        = op_of(op, f);
      m_ctrl   = code_of(k);
      m_result = calc(k, a, b);
      m_zero   = {m_result[WIDTH-1], m_result == '0};
      m_branch = WIDTH'(longint'(pc) + longint'(imm) * 4);
    end
    #1;
    check({tag, ".result"}, 64'(result_o), 64'(m_result));
    check({tag, ".zero"},   64'(zero_o),   64'(m_zero));
    check({tag, ".branch"}, 64'(branch_addr_o), 64'(m_branch));
    check({tag, ".ctrl"},   64'(alu_ctrl_o), 64'(m_ctrl));
  endtask

  logic [5:0] legal_f [6] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h2A};

  function automatic logic [WIDTH-1:0] rnd_val();
    case ($urandom_range(0, 5))
      0: return 32'h0000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'h7FFF_FFFF;
      3: return 32'h8000_0000;
      4: return WIDTH'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    m_result = 'x; m_zero = 'x; m_branch = 'x; m_ctrl = 'x;
    rst_i = 1'b0; en_i = 1'b1; alu_op_i = '0; funct_i = '0;
    src1_i = '0; src2_i = '0; pc_i = '0; imm_i = '0;
    #2;

    // Reset held two edges with live nonzero inputs, reset beats enable
    step(0, 1, 3'b010, 6'h25, 32'h55, 32'hAA, 32'h100, 32'h4, "rst0");
    step(0, 1, 3'b000, 6'h20, 32'h1,  32'h2,  32'h200, 32'h8, "rst1");
    step(1, 1, 3'b000, 6'h20, 32'h1,  32'h2,  32'h200, 32'h8, "rel");

    // R-type decode with 7 and 5
    foreach (legal_f[i])
      step(1, 1, 3'b010, legal_f[i], 32'd7, 32'd5, 32'h0, 32'h0, $sformatf("rtype%0d", i));

    step(1, 1, 3'b011, 6'h00, 32'hFFFF_FFFF, 32'h1, 32'h0, 32'h0, "slti_neg");
    step(1, 1, 3'b001, 6'h00, 32'h1234, 32'h1234, 32'h0, 32'h0, "sub_eq");
    step(1, 1, 3'b000, 6'h00, 32'h7FFF_FFFF, 32'h1, 32'h0, 32'h0, "wrap");
    step(1, 1, 3'b000, 6'h00, 32'h0, 32'h0, 32'h10, 32'hFFFF_FFFE, "br_neg");
    step(1, 1, 3'b100, 6'h00, 32'h0, 32'h0, 32'h4, 32'h3, "br_pos");

    // Stall: inputs move, outputs must hold
    for (int i = 0; i < 3; i++)
      step(1, 0, 3'(i + 4), 6'(i), $urandom, $urandom, $urandom, $urandom, $sformatf("stall%0d", i));
    step(1, 1, 3'b010, 6'h00, 32'd9, 32'd6, 32'h40, 32'h1, "unk_funct");

    // Mid-stream reset then recovery
    step(0, 1, 3'b101, 6'h00, 32'hF0F0, 32'hFF00, 32'h8, 32'h8, "rst_mid");
    step(1, 1, 3'b101, 6'h00, 32'hF0F0, 32'hFF00, 32'h8, 32'h8, "rst_rel");

    for (int n = 0; n < 400; n++) begin
      logic [5:0] f;
      f = ($urandom_range(0, 1) != 0) ? legal_f[$urandom_range(0, 5)] : 6'($urandom);
      step(($urandom_range(0, 19) != 0), ($urandom_range(0, 3) != 0), 3'($urandom), f,
           rnd_val(), rnd_val(), $urandom, rnd_val(), $sformatf("rnd%0d", n));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
